// File: rtl/led_frame_ram.sv
// LED frame buffer for the light-pen screen: one-hot pen writes (direct or
// buffered stroke), a sequential clear engine and a registered scan read port.
module led_frame_ram #(
    parameter int ROWS           = 8,
    parameter int COLS           = 8,
    parameter int DW             = 4,
    parameter int COMMIT_CYCLES  = 50_000_000,
    parameter bit CLEAR_ON_RESET = 1'b1,
    localparam int RW            = $clog2(ROWS),
    localparam int CW            = $clog2(COLS),
    localparam int TW            = $clog2(COMMIT_CYCLES + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      mode,
    input  logic            clean,
    input  logic            we,
    input  logic [DW-1:0]   data,
    input  logic [ROWS-1:0] addr_row,
    input  logic [COLS-1:0] addr_col,
    input  logic [RW-1:0]   rd_row,
    input  logic [CW-1:0]   rd_col,
    output logic [DW-1:0]   rd_data,
    output logic [RW-1:0]   last_row,
    output logic [CW-1:0]   last_col,
    output logic            last_valid,
    output logic            busy,
    output logic            stroke_pending
);

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'd0,
        MODE_STROKE = 2'd1,
        MODE_ERASE  = 2'd2,
        MODE_IDLE   = 2'd3
    } mode_e;

    typedef enum logic {
        ST_READY = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam state_e RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

    function automatic logic [RW-1:0] rowIndex(input logic [ROWS-1:0] vec);
        rowIndex = '0;
        for (int i = 0; i < ROWS; i++)
            if (vec[i]) rowIndex = RW'(i);
    endfunction

    // Index of the highest set bit; doubles as the one-hot column decoder.
    function automatic logic [CW-1:0] colIndex(input logic [COLS-1:0] vec);
        colIndex = '0;
        for (int i = 0; i < COLS; i++)
            if (vec[i]) colIndex = CW'(i);
    endfunction

    logic [COLS-1:0][DW-1:0] mem [ROWS];

    state_e          state_q, state_d;
    logic [RW-1:0]   clrRow_q, clrRow_d;
    logic            we_q, clean_q;
    logic [1:0]      mode_q;
    logic [RW-1:0]   holdRow_q, holdRow_d;
    logic [CW-1:0]   holdCol_q, holdCol_d;
    logic [DW-1:0]   holdData_q, holdData_d;
    logic            hitValid_q, hitValid_d;
    logic            directPend_q, directPend_d;
    logic [RW-1:0]   rowBuf_q, rowBuf_d;
    logic [DW-1:0]   dataBuf_q, dataBuf_d;
    logic [COLS-1:0] mask_q, mask_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [RW-1:0]   lastRow_q, lastRow_d;
    logic [CW-1:0]   lastCol_q, lastCol_d;
    logic            lastValid_q, lastValid_d;
    logic [DW-1:0]   rdData_q;

    logic            weRise, weFall, cleanRise, modeChange, hitOneHot, commitNow;
    logic [RW-1:0]   hitRow;
    logic [CW-1:0]   hitCol;
    logic            wrEn;
    logic [RW-1:0]   wrRow;
    logic [COLS-1:0] wrMask;
    logic [COLS-1:0][DW-1:0] wrWord;

    assign weRise     = we & ~we_q;
    assign weFall     = ~we & we_q;
    assign cleanRise  = clean & ~clean_q;
    assign modeChange = (mode != mode_q);
    assign hitOneHot  = $onehot(addr_row) && $onehot(addr_col);
    assign hitRow     = rowIndex(addr_row);
    assign hitCol     = colIndex(addr_col);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RESET_STATE;
            clrRow_q     <= '0;
            we_q         <= 1'b0;
            clean_q      <= 1'b0;
            mode_q       <= MODE_IDLE;
            holdRow_q    <= '0;
            holdCol_q    <= '0;
            holdData_q   <= '0;
            hitValid_q   <= 1'b0;
            directPend_q <= 1'b0;
            rowBuf_q     <= '0;
            dataBuf_q    <= '0;
            mask_q       <= '0;
            timer_q      <= '0;
            lastRow_q    <= '0;
            lastCol_q    <= '0;
            lastValid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            clrRow_q     <= clrRow_d;
            we_q         <= we;
            clean_q      <= clean;
            mode_q       <= mode;
            holdRow_q    <= holdRow_d;
            holdCol_q    <= holdCol_d;
            holdData_q   <= holdData_d;
            hitValid_q   <= hitValid_d;
            directPend_q <= directPend_d;
            rowBuf_q     <= rowBuf_d;
            dataBuf_q    <= dataBuf_d;
            mask_q       <= mask_d;
            timer_q      <= timer_d;
            lastRow_q    <= lastRow_d;
            lastCol_q    <= lastCol_d;
            lastValid_q  <= lastValid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        clrRow_d     = clrRow_q;
        holdRow_d    = holdRow_q;
        holdCol_d    = holdCol_q;
        holdData_d   = holdData_q;
        hitValid_d   = hitValid_q;
        directPend_d = 1'b0;
        rowBuf_d     = rowBuf_q;
        dataBuf_d    = dataBuf_q;
        mask_d       = mask_q;
        timer_d      = timer_q;
        lastRow_d    = lastRow_q;
        lastCol_d    = lastCol_q;
        lastValid_d  = 1'b0;
        commitNow    = 1'b0;
        wrEn         = 1'b0;
        wrRow        = '0;
        wrMask       = '0;
        wrWord       = '0;

        case (state_q)
            ST_READY: begin
                if (cleanRise && mode == MODE_ERASE) begin
                    state_d  = ST_CLEAR;
                    clrRow_d = '0;
                end
            end
            ST_CLEAR: begin
                wrEn     = 1'b1;
                wrRow    = clrRow_q;
                wrMask   = '1;
                clrRow_d = clrRow_q + RW'(1);
                if (clrRow_q == RW'(ROWS - 1)) begin
                    state_d   = ST_READY;
                    clrRow_d  = '0;
                    lastRow_d = '0;
                    lastCol_d = '0;
                end
            end
            default: state_d = ST_READY;
        endcase

        // A hit seen while clearing is forgotten so its falling edge cannot write later.
        if (weRise) begin
            hitValid_d = !busy && hitOneHot;
            if (!busy && hitOneHot) begin
                holdRow_d  = hitRow;
                holdCol_d  = hitCol;
                holdData_d = data;
            end
        end
        if (weFall) begin
            hitValid_d = 1'b0;
            if (!busy && hitValid_q && mode == MODE_DIRECT && !modeChange)
                directPend_d = 1'b1;
        end

        if (directPend_q && !modeChange && !busy) begin
            wrEn        = 1'b1;
            wrRow       = holdRow_q;
            wrMask      = COLS'(1) << holdCol_q;
            wrWord      = {COLS{holdData_q}};
            lastRow_d   = holdRow_q;
            lastCol_d   = holdCol_q;
            lastValid_d = 1'b1;
        end

        if (modeChange) begin
            mask_d  = '0;
            timer_d = '0;
        end else if (!busy && mode == MODE_STROKE) begin
            if (weRise && hitOneHot) begin
                if (|mask_q && hitRow != rowBuf_q)
                    commitNow = 1'b1;
                if (!(|mask_q) || hitRow != rowBuf_q) begin
                    rowBuf_d  = hitRow;
                    dataBuf_d = data;
                    mask_d    = COLS'(1) << hitCol;
                end else begin
                    mask_d = mask_q | (COLS'(1) << hitCol);
                end
                timer_d = '0;
            end else if (|mask_q) begin
                if (timer_q == TW'(COMMIT_CYCLES - 1)) begin
                    commitNow = 1'b1;
                    mask_d    = '0;
                    timer_d   = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
        end

        // Commit always drains the buffer as it stood at the start of this cycle.
        if (commitNow) begin
            wrEn        = 1'b1;
            wrRow       = rowBuf_q;
            wrMask      = mask_q;
            wrWord      = {COLS{dataBuf_q}};
            lastRow_d   = rowBuf_q;
            lastCol_d   = colIndex(mask_q);
            lastValid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn)
            for (int c = 0; c < COLS; c++)
                if (wrMask[c]) mem[wrRow][c] <= wrWord[c];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rdData_q <= '0;
        else if (busy)
            rdData_q <= '0;
        else
            rdData_q <= mem[rd_row][rd_col];
    end

    assign busy           = (state_q == ST_CLEAR);
    assign stroke_pending = |mask_q;
    assign rd_data        = rdData_q;
    assign last_row       = lastRow_q;
    assign last_col       = lastCol_q;
    assign last_valid     = lastValid_q;

endmodule
